// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory and status signals of the two-port memory arbiter.
`default_nettype none

interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;

  logic        err;
  logic        busy;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_MemRead;
  logic        mem_MemWrite;
  logic [31:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, err, busy,
           mem_addr, mem_wdata, mem_MemRead, mem_MemWrite
  );

  // Requester / memory side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, err, busy,
           mem_addr, mem_wdata, mem_MemRead, mem_MemWrite
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one MEM_WORDS-word memory between instruction fetch and load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed data priority.
`default_nettype none

module mem_arbiter #(
  parameter int unsigned MEM_WORDS = 64
) (
  input  wire logic     clk,
  input  wire logic     rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [31:0] c_LIMIT = 32'(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_D  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        w_if_oor;
  logic        w_d_oor;
  logic        w_pick_d;

  logic        r_if_ready;
  logic        r_d_ready;
  logic        r_err;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;

  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_wdata;
  logic        w_mem_rd;
  logic        w_mem_wr;

  // Full-width compare: high address bits must never alias into the array.
  assign w_if_oor = (bus.if_addr >= c_LIMIT);
  assign w_d_oor  = (bus.d_addr  >= c_LIMIT);

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data was granted most recently; reset value makes the first tie go to data.
  logic r_last_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_d <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_next == GNT_D) begin
        r_last_d <= 1'b1;
      end else if (w_next == GNT_IF) begin
        r_last_d <= 1'b0;
      end
    end
  end

  assign w_pick_d = bus.d_req && (!bus.if_req || !r_last_d);
`else
  assign w_pick_d = bus.d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_mem_addr  = 32'h0;
    w_mem_wdata = 32'h0;
    w_mem_rd    = 1'b0;
    w_mem_wr    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_d) begin
          w_next = GNT_D;
        end else if (bus.if_req) begin
          w_next = GNT_IF;
        end
      end
      GNT_IF: begin
        w_next = RESP;
        if (!w_if_oor) begin
          w_mem_addr = bus.if_addr;
          w_mem_rd   = 1'b1;
        end
      end
      GNT_D: begin
        w_next      = RESP;
        w_mem_wdata = bus.d_wdata;
        if (!w_d_oor) begin
          w_mem_addr = bus.d_addr;
          w_mem_rd   = !bus.d_we;
          w_mem_wr   = bus.d_we;
        end
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Ready and err are one-cycle pulses; read data holds until that port completes again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      r_err      <= 1'b0;
      r_if_rdata <= 32'h0;
      r_d_rdata  <= 32'h0;
    end else begin
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      r_err      <= 1'b0;
      if (r_state == GNT_IF) begin
        r_if_ready <= 1'b1;
        r_err      <= w_if_oor;
        r_if_rdata <= w_if_oor ? 32'h0 : bus.mem_rdata;
      end
      if (r_state == GNT_D) begin
        r_d_ready <= 1'b1;
        r_err     <= w_d_oor;
        r_d_rdata <= w_d_oor ? 32'h0 : bus.mem_rdata;
      end
    end
  end

  assign bus.if_ready     = r_if_ready;
  assign bus.d_ready      = r_d_ready;
  assign bus.err          = r_err;
  assign bus.if_rdata     = r_if_rdata;
  assign bus.d_rdata      = r_d_rdata;
  assign bus.busy         = (r_state != IDLE);
  assign bus.mem_addr     = w_mem_addr;
  assign bus.mem_wdata    = w_mem_wdata;
  assign bus.mem_MemRead  = w_mem_rd;
  assign bus.mem_MemWrite = w_mem_wr;

`ifndef SYNTHESIS
  a_no_ready_overlap: assert property (@(posedge clk) disable iff (!rst)
    !(r_if_ready && r_d_ready));
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven single-access vectors plus contention and reset sequences.
`default_nettype none

module tb_mem_arbiter;

  logic clk;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_WORDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write-through on MemWrite, image reload on reset.
  logic [31:0] mem [64];
  int          wr_count;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[0]  <= 32'h11111111;
      mem[5]  <= 32'h2402000A;
      mem[63] <= 32'h3F3F3F3F;
    end else if (bus.mem_MemWrite) begin
      mem[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (bus.mem_MemWrite) wr_count <= wr_count + 1;
  end

  assign bus.mem_rdata = bus.mem_MemWrite ? bus.mem_wdata : mem[bus.mem_addr[5:0]];

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int          n_pass;
  int          n_total;
  logic [31:0] hold_if;
  logic [31:0] hold_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v);
    int   lat;
    int   wr0;
    logic oor;
    oor = (v.addr >= 32'd64);
    wr0 = wr_count;
    bus.if_req  = !v.is_d;
    bus.if_addr = v.addr;
    bus.d_req   = v.is_d;
    bus.d_we    = v.we;
    bus.d_addr  = v.addr;
    bus.d_wdata = v.wdata;
    @(negedge clk);
    lat = 1;
    chk("grant_busy", bus.busy, 1'b1);
    chk("grant_mem_addr", bus.mem_addr, oor ? 32'h0 : v.addr);
    chk("grant_MemRead", bus.mem_MemRead, v.is_d ? (!oor && !v.we) : !oor);
    chk("grant_MemWrite", bus.mem_MemWrite, v.is_d && v.we && !oor);
    if (v.is_d && !oor) chk("grant_mem_wdata", bus.mem_wdata, v.wdata);
    while (!(bus.if_ready || bus.d_ready) && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("ready_latency", lat, 2);
    chk("ready_port", {bus.if_ready, bus.d_ready}, v.is_d ? 2'b01 : 2'b10);
    chk("err", bus.err, v.exp_err);
    if (v.is_d) hold_d = v.exp_rdata;
    else        hold_if = v.exp_rdata;
    chk("if_rdata", bus.if_rdata, hold_if);
    chk("d_rdata", bus.d_rdata, hold_d);
    chk("write_count", wr_count - wr0, (v.is_d && v.we && !oor) ? 1 : 0);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(negedge clk);
    chk("back_to_idle", {bus.busy, bus.if_ready, bus.d_ready, bus.err}, 4'b0000);
  endtask

  vec_t vecs [13];
  int   rdy_cyc_d;
  int   rdy_cyc_if;
  int   n_grants;
  logic ord [4];
  logic exp_ord [4];
  logic overlap;
  logic saw_ready;

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 32'd5,         32'h0,        32'h2402000A, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 32'd7,         32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'd7,         32'h0,        32'hDEADBEEF, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'd7,         32'h0,        32'hDEADBEEF, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 32'd63,        32'h0,        32'h3F3F3F3F, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 32'd64,        32'h0,        32'h0,        1'b1};
    vecs[6]  = '{1'b1, 1'b1, 32'd64,        32'h1,        32'h0,        1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'd0,         32'h0,        32'h11111111, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'hFFFFFFFF,  32'h0,        32'h0,        1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'h80000005,  32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b1, 1'b1, 32'd63,        32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'd63,        32'h0,        32'hCAFEF00D, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'd63,        32'h0,        32'hCAFEF00D, 1'b0};

    n_pass   = 0;
    n_total  = 0;
    wr_count = 0;
    hold_if  = 32'h0;
    hold_d   = 32'h0;
    bus.if_req  = 1'b0;
    bus.if_addr = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_flags", {bus.busy, bus.if_ready, bus.d_ready, bus.err}, 4'b0000);
    chk("reset_if_rdata", bus.if_rdata, 32'h0);
    chk("reset_d_rdata", bus.d_rdata, 32'h0);
    chk("reset_mem_ctl", {bus.mem_MemRead, bus.mem_MemWrite}, 2'b00);
    chk("reset_mem_addr", bus.mem_addr, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_vec(vecs[i]);

    // Contention, each requester dropping after its own ready: data at 2, fetch at 5
    rdy_cyc_d  = -1;
    rdy_cyc_if = -1;
    overlap    = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'd5;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'd7;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.if_ready && bus.d_ready) overlap = 1'b1;
      if (bus.d_ready && rdy_cyc_d < 0) begin
        rdy_cyc_d = c;
        bus.d_req = 1'b0;
      end
      if (bus.if_ready && rdy_cyc_if < 0) begin
        rdy_cyc_if = c;
        bus.if_req = 1'b0;
      end
    end
    chk("contend_d_cycle", rdy_cyc_d, 2);
    chk("contend_if_cycle", rdy_cyc_if, 5);
    chk("contend_no_overlap", overlap, 1'b0);
    chk("contend_d_rdata", bus.d_rdata, 32'hDEADBEEF);
    chk("contend_if_rdata", bus.if_rdata, 32'h2402000A);

    // Both requests held continuously for 12 cycles
`ifdef ARB_ROUND_ROBIN_EN
    exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    n_grants = 0;
    overlap  = 1'b0;
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.if_ready && bus.d_ready) overlap = 1'b1;
      if ((bus.if_ready || bus.d_ready) && n_grants < 4) begin
        ord[n_grants] = bus.d_ready;
        n_grants++;
      end
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    chk("stream_grant_count", n_grants, 4);
    chk("stream_no_overlap", overlap, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k < n_grants) chk($sformatf("stream_order_%0d", k), ord[k], exp_ord[k]);
    end
    repeat (2) @(negedge clk);

    // Reset asserted during a store grant
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'd9;
    bus.d_wdata = 32'h12345678;
    @(negedge clk);
    chk("rst_mid_MemWrite", bus.mem_MemWrite, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_flags", {bus.busy, bus.if_ready, bus.d_ready, bus.err}, 4'b0000);
    chk("rst_mid_mem_ctl", {bus.mem_MemRead, bus.mem_MemWrite}, 2'b00);
    chk("rst_mid_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mid_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mid_rdata", bus.if_rdata | bus.d_rdata, 32'h0);
    saw_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.d_ready || bus.if_ready || bus.busy) saw_ready = 1'b1;
    end
    chk("rst_mid_held_idle", saw_ready, 1'b0);
    bus.d_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_idle", {bus.busy, bus.d_ready}, 2'b00);
    hold_if = 32'h0;
    hold_d  = 32'h0;
    run_vec('{1'b1, 1'b0, 32'd0, 32'h0, 32'h11111111, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
